// File: rtl/div_seq_n.sv
// -----------------------------------------------------------------------------
// div_seq_n : multi-cycle radix-2 restoring integer divider (DIV / DIVU)
//
// One quotient bit is produced per clock. The result is written to HI/LO as
// Y_hi (remainder) and Y_lo (quotient), with ALU-style N/Z/V/C flags.
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   : 'sign' selects signed (DIV) or unsigned (DIVU) operation.
//               Includes magnitude conversion, sign fix-up and the
//               MIN / -1 overflow flag.
//   undefined : every operation is unsigned and 'sign' is ignored.
//               V is raised only on divide by zero.
//   Latency is the same in both builds.
//
// Handshake: 'start' is sampled only while the FSM is IDLE. It is ignored
//   while busy and is never queued. 'done' is a one-cycle pulse in the cycle
//   the results become valid; busy is already low in that cycle, so a new
//   start may be issued at once.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   start       in   request; sampled in IDLE only
//   sign        in   1 = signed, 0 = unsigned; sampled with start
//   S, T        in   dividend / divisor; sampled with start
//   busy        out  high while in CALC or FIX
//   done        out  one-cycle pulse when Y_hi/Y_lo/flags are updated
//   Y_hi        out  remainder
//   Y_lo        out  quotient
//   N, Z, V, C  out  flags (C is always 0)
//   dbg_state_o out  current FSM state (0 IDLE, 1 CALC, 2 FIX)
// -----------------------------------------------------------------------------
module div_seq_n #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y_hi,
    output logic [WIDTH-1:0] Y_lo,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             C,
    output logic [1:0]       dbg_state_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dmag_q, dmag_d;
    logic               dvz_q, dvz_d;
    logic [WIDTH-1:0]   yhi_q, yhi_d;
    logic [WIDTH-1:0]   ylo_q, ylo_d;
    logic               n_q, n_d;
    logic               z_q, z_d;
    logic               v_q, v_d;
    logic               done_q, done_d;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic               sop_q, sop_d;     // signed operation
    logic               sneg_q, sneg_d;   // dividend was negative
    logic               tneg_q, tneg_d;   // divisor was negative
    logic               ovf_q, ovf_d;     // MIN / -1
`else
    logic               unused_sign;
    assign unused_sign = sign;
`endif

    // Magnitudes of the incoming operands.
    logic [WIDTH-1:0]   s_mag;
    logic [WIDTH-1:0]   t_mag;

`ifdef DIV_SIGNED_EN
    assign s_mag = (sign && S[WIDTH-1]) ? (~S + WIDTH'(1)) : S;
    assign t_mag = (sign && T[WIDTH-1]) ? (~T + WIDTH'(1)) : T;
`else
    assign s_mag = S;
    assign t_mag = T;
`endif

    // One restoring step. The partial remainder can reach 2*dmag-1, which
    // needs WIDTH+1 bits. The difference gets one more guard bit so that its
    // MSB is a true borrow even when dmag has its top bit set.
    logic [WIDTH:0]     partial;
    logic [WIDTH+1:0]   trial;
    logic               trial_ok;
    logic               unused_trial_bit;

    assign partial          = {rem_q, quo_q[WIDTH-1]};
    assign trial            = {1'b0, partial} - {2'b00, dmag_q};
    assign trial_ok         = ~trial[WIDTH+1];
    assign unused_trial_bit = trial[WIDTH];   // always 0 when trial_ok

    // Result after sign correction; used only in FIX.
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   res_hi;
    logic               res_v;

    always_comb begin
        res_lo = quo_q;
        res_hi = rem_q;
        res_v  = 1'b0;
        if (dvz_q) begin
            // rem_q holds the raw dividend for a divide by zero.
            res_lo = '1;
            res_hi = rem_q;
            res_v  = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            if (sop_q && (sneg_q ^ tneg_q)) res_lo = ~quo_q + WIDTH'(1);
            if (sop_q && sneg_q)            res_hi = ~rem_q + WIDTH'(1);
            res_v = ovf_q;
`endif
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dmag_d  = dmag_q;
        dvz_d   = dvz_q;
        yhi_d   = yhi_q;
        ylo_d   = ylo_q;
        n_d     = n_q;
        z_d     = z_q;
        v_d     = v_q;
        done_d  = 1'b0;
`ifdef DIV_SIGNED_EN
        sop_d   = sop_q;
        sneg_d  = sneg_q;
        tneg_d  = tneg_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvz_d  = (T == '0);
                    dmag_d = t_mag;
                    cnt_d  = '0;
`ifdef DIV_SIGNED_EN
                    sop_d  = sign;
                    sneg_d = sign & S[WIDTH-1];
                    tneg_d = sign & T[WIDTH-1];
                    ovf_d  = sign && (S == MIN_VAL) && (T == '1);
`endif
                    if (T == '0) begin
                        // Skip iterations; keep S so it can be returned as-is.
                        rem_d   = S;
                        quo_d   = '1;
                        state_d = ST_FIX;
                    end else begin
                        rem_d   = '0;
                        quo_d   = s_mag;
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                rem_d = trial_ok ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], trial_ok};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                ylo_d   = res_lo;
                yhi_d   = res_hi;
                n_d     = res_lo[WIDTH-1];
                z_d     = (res_lo == '0);
                v_d     = res_v;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dmag_q  <= '0;
            dvz_q   <= 1'b0;
            yhi_q   <= '0;
            ylo_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            sop_q   <= 1'b0;
            sneg_q  <= 1'b0;
            tneg_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dmag_q  <= dmag_d;
            dvz_q   <= dvz_d;
            yhi_q   <= yhi_d;
            ylo_q   <= ylo_d;
            n_q     <= n_d;
            z_q     <= z_d;
            v_q     <= v_d;
            done_q  <= done_d;
`ifdef DIV_SIGNED_EN
            sop_q   <= sop_d;
            sneg_q  <= sneg_d;
            tneg_q  <= tneg_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done        = done_q;
    assign Y_hi        = yhi_q;
    assign Y_lo        = ylo_q;
    assign N           = n_q;
    assign Z           = z_q;
    assign V           = v_q;
    assign C           = 1'b0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_seq_n.sv
// -----------------------------------------------------------------------------
// tb_div_seq_n : directed, table-driven bench for div_seq_n (WIDTH = 32).
// Expected values are hand-computed. Where the signed and unsigned builds
// differ, DIV_SIGNED_EN selects the matching expectation.
// -----------------------------------------------------------------------------
module tb_div_seq_n;

    localparam int W       = 32;
    localparam int LAT     = W + 1;
    localparam int TIMEOUT = 100;

    logic         clk;
    logic         reset;
    logic         start;
    logic         sign;
    logic [W-1:0] S;
    logic [W-1:0] T;
    logic         busy;
    logic         done;
    logic [W-1:0] Y_hi;
    logic [W-1:0] Y_lo;
    logic         N;
    logic         Z;
    logic         V;
    logic         C;
    logic [1:0]   dbg_state_o;

    div_seq_n #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sign        (sign),
        .S           (S),
        .T           (T),
        .busy        (busy),
        .done        (done),
        .Y_hi        (Y_hi),
        .Y_lo        (Y_lo),
        .N           (N),
        .Z           (Z),
        .V           (V),
        .C           (C),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] t;
        logic         sg;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         n;
        logic         z;
        logic         v;
        int           lat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic set_vec(input int i, input logic [W-1:0] s, input logic [W-1:0] t,
                           input logic sg, input logic [W-1:0] lo, input logic [W-1:0] hi,
                           input logic n, input logic z, input logic v, input int lat);
        vecs[i].s   = s;
        vecs[i].t   = t;
        vecs[i].sg  = sg;
        vecs[i].lo  = lo;
        vecs[i].hi  = hi;
        vecs[i].n   = n;
        vecs[i].z   = z;
        vecs[i].v   = v;
        vecs[i].lat = lat;
    endtask

    task automatic fill_vecs();
        set_vec(0,  32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b0, 1'b0, LAT);
        set_vec(1,  32'hFFFFFFFF, 32'h10,       1'b0, 32'h0FFFFFFF, 32'hF,        1'b0, 1'b0, 1'b0, LAT);
        set_vec(2,  32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1'b1, 1);
        set_vec(3,  32'd7,        32'd0,        1'b1, 32'hFFFFFFFF, 32'd7,        1'b1, 1'b0, 1'b1, 1);
        set_vec(4,  32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0, LAT);
        set_vec(5,  32'd3,        32'd10,       1'b0, 32'd0,        32'd3,        1'b0, 1'b1, 1'b0, LAT);
        set_vec(6,  32'hFFFFFFFE, 32'h80000001, 1'b0, 32'd1,        32'h7FFFFFFD, 1'b0, 1'b0, 1'b0, LAT);
`ifdef DIV_SIGNED_EN
        set_vec(7,  32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, LAT);
        set_vec(8,  32'hFFFFFFFF, 32'h10,       1'b1, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, LAT);
        set_vec(9,  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b1, 1'b0, 1'b1, LAT);
        set_vec(10, 32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b1, 1'b0, 1'b0, LAT);
        set_vec(11, 32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, 32'd2,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, LAT);
`else
        set_vec(7,  32'hFFFFFFF9, 32'd2,        1'b1, 32'h7FFFFFFC, 32'd1,        1'b0, 1'b0, 1'b0, LAT);
        set_vec(8,  32'hFFFFFFFF, 32'h10,       1'b1, 32'h0FFFFFFF, 32'hF,        1'b0, 1'b0, 1'b0, LAT);
        set_vec(9,  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'h80000000, 1'b0, 1'b1, 1'b0, LAT);
        set_vec(10, 32'd7,        32'hFFFFFFFE, 1'b1, 32'd0,        32'd7,        1'b0, 1'b1, 1'b0, LAT);
        set_vec(11, 32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, 32'd0,        32'hFFFFFFF8, 1'b0, 1'b1, 1'b0, LAT);
`endif
    endtask

    // ---------------- driver ----------------
    // Issues one operation and returns #1 after the edge at which done is
    // seen (or after TIMEOUT edges). lat counts edges after the start edge.
    // Inputs are scrambled after the start edge because they must no longer
    // matter.
    task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] t, input logic sg,
                          output int lat, output logic busy_e0);
        @(negedge clk);
        start = 1'b1;
        S     = s;
        T     = t;
        sign  = sg;
        @(posedge clk);
        #1;
        start   = 1'b0;
        S       = $urandom;
        T       = $urandom;
        sign    = 1'($urandom_range(0, 1));
        busy_e0 = busy;
        lat     = 0;
        while (!done && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // ---------------- test ----------------
    int   lat;
    logic busy_e0;
    int   dones;
    int   done_at;
    logic [W-1:0] cap_lo;
    logic [W-1:0] cap_hi;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        S     = '0;
        T     = '0;
        fill_vecs();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy",  W'(busy),        '0);
        chk("rst done",  W'(done),        '0);
        chk("rst Y_hi",  Y_hi,            '0);
        chk("rst Y_lo",  Y_lo,            '0);
        chk("rst NZVC",  W'({N, Z, V, C}), '0);
        chk("rst state", W'(dbg_state_o), '0);
        @(negedge clk);
        reset = 1'b1;

        // Table of operations, issued back to back
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].s, vecs[i].t, vecs[i].sg, lat, busy_e0);
            chk($sformatf("v%0d busy_e0", i), W'(busy_e0), W'(1'b1));
            chk($sformatf("v%0d latency", i), W'(lat), W'(vecs[i].lat));
            chk($sformatf("v%0d Y_lo", i), Y_lo, vecs[i].lo);
            chk($sformatf("v%0d Y_hi", i), Y_hi, vecs[i].hi);
            chk($sformatf("v%0d N", i), W'(N), W'(vecs[i].n));
            chk($sformatf("v%0d Z", i), W'(Z), W'(vecs[i].z));
            chk($sformatf("v%0d V", i), W'(V), W'(vecs[i].v));
            chk($sformatf("v%0d C", i), W'(C), '0);
            chk($sformatf("v%0d busy@done", i), W'(busy), '0);
        end

        // Outputs hold after done
        repeat (5) @(posedge clk);
        #1;
        chk("hold done", W'(done), '0);
        chk("hold Y_lo", Y_lo, vecs[NV-1].lo);
        chk("hold Y_hi", Y_hi, vecs[NV-1].hi);

        // Second start while busy is ignored
        @(negedge clk);
        start = 1'b1; S = 32'd100; T = 32'd7; sign = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        dones   = 0;
        done_at = -1;
        cap_lo  = '0;
        cap_hi  = '0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 5) begin
                start = 1'b1; S = 32'd50; T = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (done_at < 0) begin
                    done_at = c;
                    cap_lo  = Y_lo;
                    cap_hi  = Y_hi;
                end
            end
        end
        chk("ign done count", W'(dones), W'(1));
        chk("ign latency", W'(done_at), W'(LAT));
        chk("ign Y_lo", cap_lo, 32'd14);
        chk("ign Y_hi", cap_hi, 32'd2);

        // Reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; S = 32'd200; T = 32'd9; sign = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy", W'(busy), '0);
        chk("abort done", W'(done), '0);
        chk("abort Y_lo", Y_lo, '0);
        chk("abort Y_hi", Y_hi, '0);
        chk("abort NZVC", W'({N, Z, V, C}), '0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("abort no done", W'(dones), '0);
        run_op(32'd100, 32'd7, 1'b0, lat, busy_e0);
        chk("post-rst latency", W'(lat), W'(LAT));
        chk("post-rst Y_lo", Y_lo, 32'd14);
        chk("post-rst Y_hi", Y_hi, 32'd2);

        // Reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b0; start = 1'b1; S = 32'd9; T = 32'd3;
        @(posedge clk);
        #1;
        chk("rst>start busy", W'(busy), '0);
        chk("rst>start state", W'(dbg_state_o), '0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_seq_n.md
# div_seq_n

Multi-cycle, parametrised integer divider for the enhanced MIPS datapath. It serves DIV and DIVU with a start/done handshake instead of a single-cycle combinational divide. It produces one quotient bit per clock using a radix-2 restoring algorithm. Results go to the HI/LO registers as Y_hi (remainder) and Y_lo (quotient), with N/Z/V/C flags in the same format as the ALU.

## Interface
- WIDTH, 32: operand and result width, ≥ 4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- S  in  WIDTH  dividend; sampled with start.
- T  in  WIDTH  divisor; sampled with start.
- busy  out  1  high while in CALC or FIX.
- done  out  1  one-cycle pulse when results become valid.
- Y_hi  out  WIDTH  remainder.
- Y_lo  out  WIDTH  quotient.
- N, Z, V, C  out  1 each  flags.

## Operation
- States and transitions:
  - IDLE: on start, go to CALC; if T==0, go directly to FIX.
  - CALC: WIDTH iterations, then FIX.
  - FIX: one cycle, then IDLE.
- Load (IDLE with start): latch sign_op, dividend magnitude, divisor magnitude, and the sign of each operand. Magnitude = two's-complement negate when sign_op=1 and the MSB=1; otherwise the raw value.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem − dmag, computed at WIDTH+1 bits.
  - If trial ≥ 0: rem = trial and set quo LSB to 1; otherwise restore.
  - A log2(WIDTH)+1-bit counter counts 0..WIDTH−1.
- Signed division truncates toward zero:
  - quotient is negated when the operand signs differ;
  - remainder is negated when the dividend is negative (remainder takes the dividend's sign).
- FIX: apply the sign corrections, register Y_hi/Y_lo and the flags, pulse done.
- Divide by zero (T==0, either mode): Y_lo = all ones, Y_hi = S unchanged, V=1.
- Signed overflow (S = most negative value, T = −1): Y_lo = most negative value, Y_hi = 0, V=1.
- V=0 in all other cases.
- Flags:
  - N = Y_lo[WIDTH−1];
  - Z = (Y_lo == 0);
  - C = 0 always (never X).
- Outputs hold their values until the next FIX or reset.

## Timing
- Reset (reset==0 at an edge):
  - state IDLE, counter 0;
  - busy, done, Y_hi, Y_lo, N, Z, V, C all 0.
- Reset mid-operation aborts the operation with no done pulse. Reset takes priority over start.
- Normal latency: start accepted at edge E0; busy=1 after E0; done=1 and results valid after edge E(WIDTH+1). That is WIDTH+1 clocks, 33 for WIDTH=32.
- Divide-by-zero latency: done after E1.
- busy falls in the same cycle that done rises.
- start while busy=1 is ignored, with no queueing.
- start in the cycle done is high is accepted, since the state is IDLE. Back-to-back issue therefore runs every WIDTH+2 cycles.
- S, T and sign may change freely after E0.

## Configuration
- DIV_SIGNED_EN:
  - Defined: sign selects signed or unsigned operation; magnitude conversion, sign fix-up and the MIN/−1 overflow check are all present.
  - Undefined: the sign input is ignored and all operations are unsigned. The magnitude and fix-up logic is compiled out, and V is set only on divide by zero.
  - Latency is identical in both builds.

## Test plan
- Unsigned 100 / 7, sign=0 → exactly 33 clocks after the start edge: done=1, Y_lo=14, Y_hi=2, N=0, Z=0, V=0, C=0.
- Signed −7 / 2 (S=0xFFFFFFF9, T=2) → Y_lo=0xFFFFFFFD, Y_hi=0xFFFFFFFF, N=1, V=0.
- Mode sensitivity, S=0xFFFFFFFF, T=0x10:
  - sign=0 → Y_lo=0x0FFFFFFF, Y_hi=0xF.
  - sign=1 → Y_lo=0, Y_hi=0xFFFFFFFF, Z=1.
- Divide by zero, S=5, T=0 → done after 1 clock, Y_lo=0xFFFFFFFF, Y_hi=5, V=1, N=1.
- Signed 0x80000000 / 0xFFFFFFFF → Y_lo=0x80000000, Y_hi=0, V=1, N=1.
- Control corner cases:
  - A second start pulse while busy is ignored: exactly one done, and the results belong to the first operands.
  - reset=0 at cycle 10 of an operation → busy=0, no done pulse, all outputs 0. A new start after release completes normally.
